// File: rtl/vram_arbiter.sv
// VRAM port arbiter: scanout has absolute priority, the CPU takes any free slot via req/ack.
// Latency: scan 2 cycles (req edge to scan_valid); CPU write ack +1, read ack +3 from the issue edge.
// Backpressure: scan is never stalled; cpu_req waits in IDLE while scan_req is high. Optional VRAM_BLANK_WRITE_EN.
module vram_arbiter #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hVisible,
    input  logic              vVisible,
    input  logic              scan_req,
    input  logic [ADDR_W-1:0] scan_addr,
    output logic              scan_valid,
    output logic [DATA_W-1:0] scan_data,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_ACK  = 3'd1,
        RD_WAIT = 3'd2,
        RD_DATA = 3'd3,
        RD_ACK  = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_we_q, mem_we_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic              scan_p1_q, scan_p2_q;
    logic              wr_gate;

`ifdef VRAM_BLANK_WRITE_EN
    // Writes only during blanking so the visible frame never tears.
    assign wr_gate = !hVisible || !vVisible;
`else
    logic unused_vis;
    assign unused_vis = hVisible & vVisible;
    assign wr_gate    = 1'b1;
`endif

    always_comb begin
        state_d     = state_q;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = 1'b0;
        mem_wdata_d = mem_wdata_q;
        cpu_rdata_d = cpu_rdata_q;

        if (scan_req) begin
            mem_addr_d = scan_addr;
        end

        case (state_q)
            IDLE: begin
                if (cpu_req && !scan_req && (!cpu_we || wr_gate)) begin
                    mem_addr_d = cpu_addr;
                    if (cpu_we) begin
                        mem_we_d    = 1'b1;
                        mem_wdata_d = cpu_wdata;
                        state_d     = WR_ACK;
                    end else begin
                        state_d = RD_WAIT;
                    end
                end
            end
            WR_ACK:  state_d = IDLE;
            RD_WAIT: state_d = RD_DATA;
            RD_DATA: begin
                // mem_rdata here belongs to the CPU address presented last cycle.
                cpu_rdata_d = mem_rdata;
                state_d     = RD_ACK;
            end
            RD_ACK:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            cpu_rdata_q <= '0;
            scan_p1_q   <= 1'b0;
            scan_p2_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            scan_p1_q   <= scan_req;
            scan_p2_q   <= scan_p1_q;
        end
    end

    assign mem_addr   = mem_addr_q;
    assign mem_we     = mem_we_q;
    assign mem_wdata  = mem_wdata_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign cpu_ack    = (state_q == WR_ACK) || (state_q == RD_ACK);
    assign scan_valid = scan_p2_q;
    assign scan_data  = mem_rdata;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a synchronous 1-cycle-read VRAM model.
module tb_vram_arbiter;
    localparam int ADDR_W = 15;
    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              hVisible, vVisible;
    logic              scan_req;
    logic [ADDR_W-1:0] scan_addr;
    logic              scan_valid;
    logic [DATA_W-1:0] scan_data;
    logic              cpu_req, cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic [DATA_W-1:0] vram [0:(1<<ADDR_W)-1];

    int n_vec = 0;
    int n_err = 0;

    vram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .hVisible(hVisible), .vVisible(vVisible),
        .scan_req(scan_req), .scan_addr(scan_addr),
        .scan_valid(scan_valid), .scan_data(scan_data),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) vram[mem_addr] <= mem_wdata;
        mem_rdata <= vram[mem_addr];
    end

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        scan_req  = 1'b0;
        scan_addr = '0;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
    endtask

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) vram[i] = i[DATA_W-1:0];
        mem_rdata = '0;
        hVisible  = 1'b0;
        vVisible  = 1'b0;

        // 1: reset with random inputs
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            scan_req  = 1'($urandom);
            scan_addr = ADDR_W'($urandom);
            cpu_req   = 1'($urandom);
            cpu_we    = 1'($urandom);
            cpu_addr  = ADDR_W'($urandom);
            cpu_wdata = DATA_W'($urandom);
            tick();
            check_vec("rst_mem_addr", 32'(mem_addr), 32'h0);
            check_vec("rst_mem_we", 32'(mem_we), 32'h0);
            check_vec("rst_mem_wdata", 32'(mem_wdata), 32'h0);
            check_vec("rst_scan_valid", 32'(scan_valid), 32'h0);
            check_vec("rst_cpu_ack", 32'(cpu_ack), 32'h0);
            check_vec("rst_cpu_rdata", 32'(cpu_rdata), 32'h0);
        end
        idle_inputs();
        tick();
        rst = 1'b0;
        tick();

        // 2: four back-to-back scan reads 0x10..0x13
        for (int k = 0; k < 8; k++) begin
            scan_req  = (k < 4);
            scan_addr = ADDR_W'(32'h10 + k);
            tick();
            if (k < 4) check_vec("scan_mem_addr", 32'(mem_addr), 32'h10 + k);
            check_vec("scan_mem_we", 32'(mem_we), 32'h0);
            check_vec("scan_valid", 32'(scan_valid), 32'((k >= 1) && (k <= 4)));
            if (k >= 1 && k <= 4) check_vec("scan_data", 32'(scan_data), 32'h10 + k - 1);
        end
        idle_inputs();

        // 3: CPU write then read back
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h1234; cpu_wdata = 8'hAB;
        tick();
        check_vec("wr_mem_we", 32'(mem_we), 32'h1);
        check_vec("wr_mem_addr", 32'(mem_addr), 32'h1234);
        check_vec("wr_mem_wdata", 32'(mem_wdata), 32'hAB);
        check_vec("wr_ack", 32'(cpu_ack), 32'h1);
        cpu_req = 1'b0;
        tick();
        check_vec("wr_ack_pulse", 32'(cpu_ack), 32'h0);
        check_vec("wr_we_drop", 32'(mem_we), 32'h0);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h1234;
        tick();
        check_vec("rd_mem_addr", 32'(mem_addr), 32'h1234);
        check_vec("rd_mem_we", 32'(mem_we), 32'h0);
        check_vec("rd_ack_n1", 32'(cpu_ack), 32'h0);
        tick();
        check_vec("rd_ack_n2", 32'(cpu_ack), 32'h0);
        tick();
        check_vec("rd_ack_n3", 32'(cpu_ack), 32'h1);
        check_vec("rd_rdata", 32'(cpu_rdata), 32'hAB);
        cpu_req = 1'b0;
        tick();
        check_vec("rd_ack_pulse", 32'(cpu_ack), 32'h0);
        check_vec("rd_rdata_hold", 32'(cpu_rdata), 32'hAB);

        // 4: pending write starved by 10 scan cycles
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h0042; cpu_wdata = 8'h5A;
        for (int k = 0; k < 10; k++) begin
            scan_req  = 1'b1;
            scan_addr = ADDR_W'(32'h100 + k);
            tick();
            check_vec("busy_mem_we", 32'(mem_we), 32'h0);
            check_vec("busy_cpu_ack", 32'(cpu_ack), 32'h0);
            check_vec("busy_mem_addr", 32'(mem_addr), 32'h100 + k);
        end
        scan_req = 1'b0;
        tick();
        check_vec("free_mem_we", 32'(mem_we), 32'h1);
        check_vec("free_mem_addr", 32'(mem_addr), 32'h42);
        check_vec("free_cpu_ack", 32'(cpu_ack), 32'h1);
        idle_inputs();
        tick();
        check_vec("free_vram", 32'(vram[15'h0042]), 32'h5A);

        // 5: write gating by visible region; reads never gated
        hVisible = 1'b1; vVisible = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h0077; cpu_wdata = 8'h33;
`ifdef VRAM_BLANK_WRITE_EN
        for (int k = 0; k < 3; k++) begin
            tick();
            check_vec("gate_mem_we", 32'(mem_we), 32'h0);
            check_vec("gate_cpu_ack", 32'(cpu_ack), 32'h0);
        end
        hVisible = 1'b0;
`endif
        tick();
        check_vec("gate_wr_we", 32'(mem_we), 32'h1);
        check_vec("gate_wr_addr", 32'(mem_addr), 32'h77);
        check_vec("gate_wr_ack", 32'(cpu_ack), 32'h1);
        cpu_req = 1'b0;
        hVisible = 1'b1;
        tick();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0077;
        tick();
        check_vec("vis_rd_addr", 32'(mem_addr), 32'h77);
        tick();
        tick();
        check_vec("vis_rd_ack", 32'(cpu_ack), 32'h1);
        check_vec("vis_rd_data", 32'(cpu_rdata), 32'h33);
        idle_inputs();
        hVisible = 1'b0; vVisible = 1'b0;
        tick();

        // 6: reset during RD_WAIT drops the read
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0010;
        tick();
        check_vec("abort_rd_addr", 32'(mem_addr), 32'h10);
        rst = 1'b1;
        cpu_req = 1'b0;
        tick();
        check_vec("abort_ack", 32'(cpu_ack), 32'h0);
        check_vec("abort_mem_addr", 32'(mem_addr), 32'h0);
        check_vec("abort_rdata", 32'(cpu_rdata), 32'h0);
        check_vec("abort_scan_valid", 32'(scan_valid), 32'h0);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check_vec("abort_no_ack", 32'(cpu_ack), 32'h0);
            check_vec("abort_rdata_keep", 32'(cpu_rdata), 32'h0);
        end
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h0055; cpu_wdata = 8'h66;
        tick();
        check_vec("post_wr_ack", 32'(cpu_ack), 32'h1);
        check_vec("post_wr_we", 32'(mem_we), 32'h1);
        check_vec("post_wr_data", 32'(mem_wdata), 32'h66);
        idle_inputs();
        tick();
        check_vec("post_wr_done", 32'(cpu_ack), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
